apb_spi_target: RTL



---
 rtl/apb_spi_target_pkg.sv | 17 +
 rtl/apb_spi_target_sync.sv | 32 +++
 rtl/apb_spi_target.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/apb_spi_target_pkg.sv
// apb_spi_target shared definitions: register offsets, STATUS bit
// positions and the read value returned for undecoded offsets.
package apb_spi_target_pkg;

    localparam logic [7:0] REG_DATA   = 8'h00;
    localparam logic [7:0] REG_STATUS = 8'h04;
    localparam logic [7:0] REG_IRQEN  = 8'h08;

    localparam int ST_RX_VALID = 0;
    localparam int ST_TX_FULL  = 1;
    localparam int ST_RX_OVR   = 2;
    localparam int ST_BUSY     = 3;
    localparam int ST_TX_URUN  = 4;

    localparam logic [31:0] UNMAPPED_RDATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/apb_spi_target_sync.sv
// spi_in_sync: multi-flop synchronizer for one SPI pin followed by an
// edge-detect flop producing single-cycle rise/fall pulses.
module spi_in_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/apb_spi_target.sv
// Mode-0 SPI target with APB DATA/STATUS window.
// Define APB_SPI_TARGET_IRQ_EN to add the IRQEN register and irq output.
module apb_spi_target
    import apb_spi_target_pkg::*;
#(
    parameter logic [7:0] FILL_BYTE   = 8'hFF,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  apb_paddr,
    input  logic        apb_psel,
    input  logic        apb_penable,
    input  logic        apb_pwrite,
    input  logic [31:0] apb_pwdata,
    output logic [31:0] apb_prdata,
    output logic        apb_pready,
    input  logic        spi_sclk,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe
`ifdef APB_SPI_TARGET_IRQ_EN
    ,
    output logic        irq
`endif
);

    logic sclk_rise, sclk_fall, unused_sclk_lvl;
    logic cs_n_lvl, cs_rise, cs_fall;
    logic mosi_lvl, unused_mosi_rise, unused_mosi_fall;

    spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
        .clk(clk), .reset(reset), .din(spi_sclk),
        .level(unused_sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
    );

    // CS syncs reset to idle-high so reset never fakes a frame start
    spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
        .clk(clk), .reset(reset), .din(spi_cs_n),
        .level(cs_n_lvl), .rise(cs_rise), .fall(cs_fall)
    );

    spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
        .clk(clk), .reset(reset), .din(spi_mosi),
        .level(mosi_lvl), .rise(unused_mosi_rise), .fall(unused_mosi_fall)
    );

    logic [6:0] rx_sh;
    logic [7:0] rx_data, tx_data, tx_sh;
    logic [2:0] bitcnt;
    logic       rx_valid, rx_ovr, tx_full, tx_urun, load_next;

    logic acc, sel_data, sel_status;
    logic data_rd, data_wr, stat_wr;
    logic cs_low, shift_rise, shift_fall, rx_done, tx_load;

    assign acc        = apb_psel & apb_penable;
    assign sel_data   = apb_paddr[3:2] == REG_DATA[3:2];
    assign sel_status = apb_paddr[3:2] == REG_STATUS[3:2];
    assign data_rd    = acc & ~apb_pwrite & sel_data;
    assign data_wr    = acc & apb_pwrite & sel_data;
    assign stat_wr    = acc & apb_pwrite & sel_status;

    assign cs_low     = ~cs_n_lvl;
    assign shift_rise = sclk_rise & cs_low;
    assign shift_fall = sclk_fall & cs_low;
    assign rx_done    = shift_rise & (bitcnt == 3'd7);
    assign tx_load    = cs_fall | (shift_fall & load_next);

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_sh     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            rx_ovr    <= 1'b0;
            tx_data   <= '0;
            tx_full   <= 1'b0;
            tx_urun   <= 1'b0;
            tx_sh     <= FILL_BYTE;
            bitcnt    <= '0;
            load_next <= 1'b0;
        end else begin
            if (cs_fall | cs_rise)
                bitcnt <= '0;
            else if (shift_rise)
                bitcnt <= bitcnt + 3'd1;

            if (cs_fall)
                load_next <= 1'b0;
            else if (rx_done)
                load_next <= 1'b1;
            else if (shift_fall)
                load_next <= 1'b0;

            if (shift_rise)
                rx_sh <= {rx_sh[5:0], mosi_lvl};
            if (rx_done)
                rx_data <= {rx_sh, mosi_lvl};

            if (rx_done)
                rx_valid <= 1'b1;
            else if (data_rd)
                rx_valid <= 1'b0;

            // A read landing with completion hands over cleanly
            if (rx_done & rx_valid & ~data_rd)
                rx_ovr <= 1'b1;
            else if (stat_wr & apb_pwdata[ST_RX_OVR])
                rx_ovr <= 1'b0;

            if (tx_load)
                tx_sh <= tx_full ? tx_data : FILL_BYTE;
            else if (shift_fall)
                tx_sh <= {tx_sh[6:0], 1'b0};

            if (data_wr)
                tx_full <= 1'b1;
            else if (tx_load)
                tx_full <= 1'b0;

            if (data_wr)
                tx_data <= apb_pwdata[7:0];

            if (tx_load & ~tx_full)
                tx_urun <= 1'b1;
            else if (stat_wr & apb_pwdata[ST_TX_URUN])
                tx_urun <= 1'b0;
        end
    end

    logic [31:0] status;

    always_comb begin
        status              = '0;
        status[ST_RX_VALID] = rx_valid;
        status[ST_TX_FULL]  = tx_full;
        status[ST_RX_OVR]   = rx_ovr;
        status[ST_BUSY]     = cs_low;
        status[ST_TX_URUN]  = tx_urun;
    end

`ifdef APB_SPI_TARGET_IRQ_EN
    logic       sel_irqen;
    logic [2:0] irqen;
    logic       irq_q;

    assign sel_irqen = apb_paddr[3:2] == REG_IRQEN[3:2];

    always_ff @(posedge clk) begin
        if (reset) begin
            irqen <= '0;
            irq_q <= 1'b0;
        end else begin
            if (acc & apb_pwrite & sel_irqen)
                irqen <= apb_pwdata[2:0];
            irq_q <= |(irqen & {rx_ovr, ~tx_full, rx_valid});
        end
    end

    assign irq = irq_q;
`endif

    always_comb begin
        apb_prdata = UNMAPPED_RDATA;
        unique case (1'b1)
            sel_data:   apb_prdata = {24'b0, rx_data};
            sel_status: apb_prdata = status;
`ifdef APB_SPI_TARGET_IRQ_EN
            sel_irqen:  apb_prdata = {29'b0, irqen};
`endif
            default:    ;
        endcase
    end

    logic unused_bits;
    assign unused_bits = ^{apb_paddr[7:4], apb_paddr[1:0], apb_pwdata[31:8]};

    assign apb_pready  = 1'b1;
    assign spi_miso    = tx_sh[7];
    assign spi_miso_oe = cs_low;

endmodule
